mem_arbiter: RTL and testbench

- Single-port memory arbiter for the multicycle RV32 core.
- Shares one synchronous RAM port between two requesters: the instruction-fetch path (pc/ce) and the load/store path (mem stage).
- Sequences each access through a small FSM that covers RAM read latency.
- Returns read data or a write acknowledgement to the requester that owns the access.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter sharing one port between fetch and load/store
// Optional: define ARB_RR_EN for round-robin arbitration on simultaneous requests.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              req_any;
  logic              pick_d;
  logic              grant;
  logic              capture;

  assign req_any = if_req | d_req;
  assign grant   = (state_q == S_IDLE) && req_any;
  assign capture = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // owner_q is 1 for the data path; it doubles as the last-owner record for round-robin.
  always_comb begin
    pick_d = d_req;
`ifdef ARB_RR_EN
    if (if_req && d_req) begin
      pick_d = ~owner_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = S_ISSUE;
      S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (grant) begin
      owner_d = pick_d;
      we_d    = pick_d & d_we;
      addr_d  = pick_d ? d_addr : if_addr;
      wdata_d = d_wdata;
    end
    if (state_q == S_ISSUE) begin
      cnt_d = LAT_M1;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 4'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      if (capture && owner_q) begin
        d_rdata_q <= ram_rdata;
      end
      if (capture && !owner_q) begin
        if_rdata_q <= ram_rdata;
      end
    end
  end

  // Grants are combinational from IDLE; rst gates them so every output is 0 during reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!rst) begin
          d_gnt  = pick_d;
          if_gnt = if_req & ~pick_d;
        end
      end
      S_ISSUE: begin
        ram_ce   = 1'b1;
        ram_addr = addr_q;
        if (we_q) begin
          ram_we    = 1'b1;
          ram_wdata = wdata_q;
        end
      end
      S_RESP: begin
        d_rvalid  = owner_q;
        if_rvalid = ~owner_q;
      end
      default: ;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at RAM_LAT 1 and 4
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ram_ce, ram_we, busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        if_req_4, if_gnt_4, if_rvalid_4;
  logic [31:0] if_addr_4, if_rdata_4;
  logic        d_req_4, d_we_4, d_gnt_4, d_rvalid_4;
  logic [31:0] d_addr_4, d_wdata_4, d_rdata_4;
  logic        ram_ce_4, ram_we_4, busy_4;
  logic [31:0] ram_addr_4, ram_wdata_4, ram_rdata_4;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req_4), .if_addr(if_addr_4), .if_gnt(if_gnt_4), .if_rvalid(if_rvalid_4), .if_rdata(if_rdata_4),
    .d_req(d_req_4), .d_we(d_we_4), .d_addr(d_addr_4), .d_wdata(d_wdata_4),
    .d_gnt(d_gnt_4), .d_rvalid(d_rvalid_4), .d_rdata(d_rdata_4),
    .ram_ce(ram_ce_4), .ram_we(ram_we_4), .ram_addr(ram_addr_4), .ram_wdata(ram_wdata_4),
    .ram_rdata(ram_rdata_4), .busy(busy_4)
  );

  // RAM models: data is valid only in the exact cycle RAM_LAT after the read strobe.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0BAD0;
  endfunction

  logic        v1 = 1'b0;
  logic [31:0] p1;
  logic [3:0]  v4 = 4'd0;
  logic [31:0] p4 [4];

  always @(posedge clk) begin
    v1    <= ram_ce & ~ram_we;
    p1    <= rd(ram_addr);
    v4    <= {v4[2:0], ram_ce_4 & ~ram_we_4};
    p4[0] <= rd(ram_addr_4);
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end

  assign ram_rdata   = v1 ? p1 : 32'hBAD0BAD0;
  assign ram_rdata_4 = v4[3] ? p4[3] : 32'hBAD0BAD0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    mem[32'h0000_0100] = 32'h0050_0093;
    mem[32'h0000_0104] = 32'h00A0_0113;
    mem[32'h0000_0108] = 32'h00F0_0193;
    mem[32'h0000_0200] = 32'h1111_1111;
    mem[32'h0000_0204] = 32'h2222_2222;
    mem[32'h0000_3000] = 32'hCAFE_0001;
    mem[32'h0000_4000] = 32'h1234_5678;
    mem[32'h0000_4004] = 32'h55AA_55AA;

    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    if_req_4 = 1'b0; if_addr_4 = 32'h0; d_req_4 = 1'b0; d_we_4 = 1'b0; d_addr_4 = 32'h0; d_wdata_4 = 32'h0;

    // reset: requests high but every output must be 0
    nx(); #1;
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ram_ce", ram_ce, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    if_req = 1'b0; d_req = 1'b0;
    nx(); rst = 1'b0;

    // first tie: data wins in both builds (last owner resets to IF)
    nx(); if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_addr = 32'h3000; #1;
    chk1("tie1_c0_d_gnt", d_gnt, 1'b1);
    chk1("tie1_c0_if_gnt", if_gnt, 1'b0);
    nx(); d_req = 1'b0; d_addr = 32'h0; #1;
    chk1("tie1_c1_if_gnt", if_gnt, 1'b0);
    chk32("tie1_c1_ram_addr", ram_addr, 32'h3000);
    nx(); #1;
    chk1("tie1_c2_d_rvalid", d_rvalid, 1'b0);
    nx(); #1;
    chk1("tie1_c3_d_rvalid", d_rvalid, 1'b1);
    chk32("tie1_c3_d_rdata", d_rdata, 32'hCAFE_0001);
    chk1("tie1_c3_if_gnt", if_gnt, 1'b0);
    nx(); #1;
    chk1("tie1_c4_if_gnt", if_gnt, 1'b1);
    chk1("tie1_c4_busy", busy, 1'b0);
    nx(); if_req = 1'b0; #1;
    chk32("tie1_c5_ram_addr", ram_addr, 32'h104);
    nx(); nx(); #1;
    chk1("tie1_c7_if_rvalid", if_rvalid, 1'b1);
    chk32("tie1_c7_if_rdata", if_rdata, 32'h00A0_0113);
    chk1("tie1_c7_d_rvalid", d_rvalid, 1'b0);

    // fetch read, RAM_LAT=1
    nx(); nx(); if_req = 1'b1; if_addr = 32'h100; #1;
    chk1("f1_c0_if_gnt", if_gnt, 1'b1);
    chk1("f1_c0_d_gnt", d_gnt, 1'b0);
    chk1("f1_c0_busy", busy, 1'b0);
    nx(); if_req = 1'b0; if_addr = 32'h0; #1;
    chk1("f1_c1_ram_ce", ram_ce, 1'b1);
    chk32("f1_c1_ram_addr", ram_addr, 32'h100);
    chk1("f1_c1_ram_we", ram_we, 1'b0);
    chk1("f1_c1_busy", busy, 1'b1);
    nx(); #1;
    chk1("f1_c2_ram_ce", ram_ce, 1'b0);
    chk1("f1_c2_if_rvalid", if_rvalid, 1'b0);
    chk1("f1_c2_busy", busy, 1'b1);
    nx(); #1;
    chk1("f1_c3_if_rvalid", if_rvalid, 1'b1);
    chk32("f1_c3_if_rdata", if_rdata, 32'h0050_0093);
    chk1("f1_c3_busy", busy, 1'b1);
    nx(); #1;
    chk1("f1_c4_if_rvalid", if_rvalid, 1'b0);
    chk1("f1_c4_busy", busy, 1'b0);
    chk32("f1_c4_if_rdata_hold", if_rdata, 32'h0050_0093);

    // store
    nx(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; #1;
    chk1("st_c0_d_gnt", d_gnt, 1'b1);
    nx(); d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; #1;
    chk1("st_c1_ram_ce", ram_ce, 1'b1);
    chk1("st_c1_ram_we", ram_we, 1'b1);
    chk32("st_c1_ram_addr", ram_addr, 32'h2004);
    chk32("st_c1_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    nx(); #1;
    chk1("st_c2_d_rvalid", d_rvalid, 1'b1);
    chk32("st_c2_d_rdata_kept", d_rdata, 32'hCAFE_0001);
    chk1("st_c2_ram_we", ram_we, 1'b0);
    chk32("st_c2_ram_wdata", ram_wdata, 32'h0);
    nx(); #1;
    chk1("st_c3_d_rvalid", d_rvalid, 1'b0);
    chk1("st_c3_busy", busy, 1'b0);

    // second tie right after a data grant
    nx(); if_req = 1'b1; if_addr = 32'h108; d_req = 1'b1; d_addr = 32'h3000; #1;
`ifdef ARB_RR_EN
    chk1("tie2_if_gnt", if_gnt, 1'b1);
    chk1("tie2_d_gnt", d_gnt, 1'b0);
`else
    chk1("tie2_if_gnt", if_gnt, 1'b0);
    chk1("tie2_d_gnt", d_gnt, 1'b1);
`endif
    nx(); if_req = 1'b0; d_req = 1'b0; nx(); nx(); nx(); #1;
    chk1("tie2_c4_busy", busy, 1'b0);

    // back-to-back fetches with if_req held
    nx(); if_req = 1'b1; if_addr = 32'h200; #1;
    chk1("bb_c0_if_gnt", if_gnt, 1'b1);
    nx(); if_addr = 32'h204; #1;
    chk1("bb_c1_if_gnt", if_gnt, 1'b0);
    chk32("bb_c1_ram_addr", ram_addr, 32'h200);
    nx(); #1;
    chk1("bb_c2_if_gnt", if_gnt, 1'b0);
    nx(); #1;
    chk1("bb_c3_if_rvalid", if_rvalid, 1'b1);
    chk32("bb_c3_if_rdata", if_rdata, 32'h1111_1111);
    chk1("bb_c3_if_gnt", if_gnt, 1'b0);
    nx(); #1;
    chk1("bb_c4_if_gnt", if_gnt, 1'b1);
    chk1("bb_c4_if_rvalid", if_rvalid, 1'b0);
    chk32("bb_c4_if_rdata", if_rdata, 32'h1111_1111);
    nx(); if_req = 1'b0; #1;
    chk32("bb_c5_ram_addr", ram_addr, 32'h204);
    chk32("bb_c5_if_rdata", if_rdata, 32'h1111_1111);
    nx(); #1;
    chk32("bb_c6_if_rdata", if_rdata, 32'h1111_1111);
    nx(); #1;
    chk1("bb_c7_if_rvalid", if_rvalid, 1'b1);
    chk32("bb_c7_if_rdata", if_rdata, 32'h2222_2222);
    nx(); #1;
    chk1("bb_c8_if_gnt", if_gnt, 1'b0);
    chk1("bb_c8_busy", busy, 1'b0);

    // RAM_LAT=4 load
    nx(); d_req_4 = 1'b1; d_addr_4 = 32'h4000; #1;
    chk1("l4_c0_d_gnt", d_gnt_4, 1'b1);
    chk1("l4_c0_if_gnt", if_gnt_4, 1'b0);
    nx(); d_req_4 = 1'b0; d_addr_4 = 32'h0; #1;
    chk1("l4_c1_ram_ce", ram_ce_4, 1'b1);
    chk32("l4_c1_ram_addr", ram_addr_4, 32'h4000);
    chk1("l4_c1_ram_we", ram_we_4, 1'b0);
    chk32("l4_c1_ram_wdata", ram_wdata_4, 32'h0);
    for (int i = 2; i <= 5; i++) begin
      nx(); #1;
      chk1($sformatf("l4_c%0d_ram_ce", i), ram_ce_4, 1'b0);
      chk1($sformatf("l4_c%0d_d_rvalid", i), d_rvalid_4, 1'b0);
    end
    nx(); #1;
    chk1("l4_c6_d_rvalid", d_rvalid_4, 1'b1);
    chk32("l4_c6_d_rdata", d_rdata_4, 32'h1234_5678);
    chk1("l4_c6_ram_ce", ram_ce_4, 1'b0);
    chk1("l4_c6_if_rvalid", if_rvalid_4, 1'b0);
    nx(); #1;
    chk1("l4_c7_d_rvalid", d_rvalid_4, 1'b0);
    chk1("l4_c7_busy", busy_4, 1'b0);

    // reset asserted while the RAM_LAT=4 load sits in WAIT
    nx(); d_req_4 = 1'b1; d_addr_4 = 32'h4000; #1;
    chk1("rw_c0_d_gnt", d_gnt_4, 1'b1);
    nx(); d_req_4 = 1'b0; d_addr_4 = 32'h0; nx(); nx(); #1;
    chk1("rw_c3_busy_pre", busy_4, 1'b1);
    rst = 1'b1; #1;
    chk1("rw_async_busy", busy_4, 1'b0);
    chk32("rw_async_d_rdata", d_rdata_4, 32'h0);
    chk32("rw_async_if_rdata_main", if_rdata, 32'h0);
    chk32("rw_async_d_rdata_main", d_rdata, 32'h0);
    chk1("rw_async_ram_ce", ram_ce_4, 1'b0);
    nx(); rst = 1'b0; if_req_4 = 1'b1; if_addr_4 = 32'h4004; #1;
    chk1("rw_rel_if_gnt", if_gnt_4, 1'b1);
    chk1("rw_rel_d_rvalid", d_rvalid_4, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      nx();
      if (i == 1) begin
        if_req_4 = 1'b0; if_addr_4 = 32'h0;
      end
      #1;
      chk1($sformatf("rw_post%0d_d_rvalid", i), d_rvalid_4, 1'b0);
    end
    chk1("rw_new_if_rvalid", if_rvalid_4, 1'b1);
    chk32("rw_new_if_rdata", if_rdata_4, 32'h55AA_55AA);
    chk32("rw_d_rdata_zero", d_rdata_4, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
